// File: rtl/fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit
//
// Operand forwarding and ID-stage hazard control for an in-order pipeline.
// Sits beside the ID/EX pipeline register.
//  - Forwarding: for each of NUM_SRC EX-stage operands, picks the nearest of
//    NUM_FWD downstream write-back stages that writes the same register.
//  - Load-use: stalls ID for one cycle when it reads the destination of a load
//    currently in EX.
//  - Scoreboard: one pending bit per architectural register, owed by the
//    multi-cycle (MUL/DIV) unit. It blocks RAW readers and WAW re-issues.
//
// Ports
//   clk, rst         : clock, synchronous active-high reset
//   rs_ex            : EX source registers, slice i = source i
//   rd_fwd           : destination of each forwarding stage (0 = nearest)
//   regwrite_fwd     : register-write enable of each forwarding stage
//   rs_id            : ID source registers
//   rs_used_id       : ID source i is actually read
//   memread_ex       : EX instruction is a load
//   rd_ex            : EX destination
//   long_issue       : ID instruction dispatches to the multi-cycle unit
//   long_rd          : destination of that dispatch
//   long_done        : multi-cycle result written to the register file
//   long_done_rd     : destination of that result
//   cnt_clr          : clear the stall counter
//   fwd_sel          : per-source mux select (0 = RF/ID-EX, k = stage k-1)
//   stall_id         : hold PC and IF/ID, insert bubble into ID/EX
//   lu_stall         : load-use part of stall_id
//   sb_stall         : scoreboard part of stall_id
//   pending          : scoreboard bits (registered)
//   stall_cnt        : saturating stall-cycle counter (registered)
// -----------------------------------------------------------------------------
module fwd_hazard_unit #(
  parameter int  NUM_SRC = 2,
  parameter int  NUM_FWD = 2,
  parameter int  AW      = 5,
  parameter int  CNT_W   = 16,
  localparam int SW      = $clog2(NUM_FWD + 1),
  localparam int NREG    = 2 ** AW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_SRC*AW-1:0]  rs_ex,
  input  logic [NUM_FWD*AW-1:0]  rd_fwd,
  input  logic [NUM_FWD-1:0]     regwrite_fwd,
  input  logic [NUM_SRC*AW-1:0]  rs_id,
  input  logic [NUM_SRC-1:0]     rs_used_id,
  input  logic                   memread_ex,
  input  logic [AW-1:0]          rd_ex,
  input  logic                   long_issue,
  input  logic [AW-1:0]          long_rd,
  input  logic                   long_done,
  input  logic [AW-1:0]          long_done_rd,
  input  logic                   cnt_clr,
  output logic [NUM_SRC*SW-1:0]  fwd_sel,
  output logic                   stall_id,
  output logic                   lu_stall,
  output logic                   sb_stall,
  output logic [NREG-1:0]        pending,
  output logic [CNT_W-1:0]       stall_cnt
);

  logic [NREG-1:0]    pending_q;
  logic [NREG-1:0]    pending_d;
  logic [CNT_W-1:0]   stall_cnt_q;
  logic [CNT_W-1:0]   stall_cnt_d;

  logic [NUM_FWD-1:0] fwd_valid;
  logic               lu_hit;
  logic               raw_hit;
  logic               waw_hit;
  logic               issue_set;
  logic [NREG-1:0]    set_mask;
  logic [NREG-1:0]    clr_mask;

  // Forwarding stage qualifies only when it writes a non-zero register.
  always_comb begin
    fwd_valid = {NUM_FWD{1'b0}};
    for (int k = 0; k < NUM_FWD; k++) begin
      fwd_valid[k] = regwrite_fwd[k] && (rd_fwd[k*AW +: AW] != {AW{1'b0}});
    end
  end

  // Forward select per source; scanning oldest to nearest lets the nearest
  // matching stage overwrite older matches.
  always_comb begin
    fwd_sel = {(NUM_SRC*SW){1'b0}};
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
        fwd_sel[i*SW +: SW] =
          (fwd_valid[k] && (rd_fwd[k*AW +: AW] == rs_ex[i*AW +: AW])) ?
          SW'(k + 1) : fwd_sel[i*SW +: SW];
      end
    end
  end

  // Load-use detection against the load currently in EX.
  always_comb begin
    lu_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      lu_hit = lu_hit | (rs_used_id[i] && (rs_id[i*AW +: AW] == rd_ex));
    end
    lu_stall = memread_ex && (rd_ex != {AW{1'b0}}) && lu_hit;
  end

  // Scoreboard hazards; register 0 is never pending so needs no extra guard
  // on the RAW side.
  always_comb begin
    raw_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      raw_hit = raw_hit | (rs_used_id[i] && pending_q[rs_id[i*AW +: AW]]);
    end
    waw_hit  = long_issue && (long_rd != {AW{1'b0}}) && pending_q[long_rd];
    sb_stall = raw_hit | waw_hit;
    stall_id = lu_stall | sb_stall;
  end

  // Next scoreboard state: clear from completion, then set from an accepted
  // issue so that a same-cycle set wins.
  always_comb begin
    issue_set = long_issue && !stall_id && (long_rd != {AW{1'b0}});
    clr_mask  = long_done ? ({{(NREG-1){1'b0}}, 1'b1} << long_done_rd)
                          : {NREG{1'b0}};
    set_mask  = issue_set ? ({{(NREG-1){1'b0}}, 1'b1} << long_rd)
                          : {NREG{1'b0}};
    pending_d = (pending_q & ~clr_mask) | set_mask;
  end

  // Next stall counter value: clear has priority, increment saturates.
  always_comb begin
    if (cnt_clr) begin
      stall_cnt_d = {CNT_W{1'b0}};
    end else if (stall_id && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1'b1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q   <= {NREG{1'b0}};
      stall_cnt_q <= {CNT_W{1'b0}};
    end else begin
      pending_q   <= pending_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign pending   = pending_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

  localparam int NUM_SRC = 2;
  localparam int NUM_FWD = 2;
  localparam int AW      = 5;
  localparam int SW      = 2;
  localparam int NREG    = 32;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_SRC*AW-1:0] rs_ex;
  logic [NUM_FWD*AW-1:0] rd_fwd;
  logic [NUM_FWD-1:0]    regwrite_fwd;
  logic [NUM_SRC*AW-1:0] rs_id;
  logic [NUM_SRC-1:0]    rs_used_id;
  logic                  memread_ex;
  logic [AW-1:0]         rd_ex;
  logic                  long_issue;
  logic [AW-1:0]         long_rd;
  logic                  long_done;
  logic [AW-1:0]         long_done_rd;
  logic                  cnt_clr;

  logic [NUM_SRC*SW-1:0] fwd_sel;
  logic                  stall_id, lu_stall, sb_stall;
  logic [NREG-1:0]       pending;
  logic [15:0]           stall_cnt;

  logic [NUM_SRC*SW-1:0] fwd_sel2;
  logic                  stall_id2, lu_stall2, sb_stall2;
  logic [NREG-1:0]       pending2;
  logic [1:0]            stall_cnt2;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.NUM_SRC(2), .NUM_FWD(2), .AW(5), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .rs_ex(rs_ex), .rd_fwd(rd_fwd),
    .regwrite_fwd(regwrite_fwd), .rs_id(rs_id), .rs_used_id(rs_used_id),
    .memread_ex(memread_ex), .rd_ex(rd_ex), .long_issue(long_issue),
    .long_rd(long_rd), .long_done(long_done), .long_done_rd(long_done_rd),
    .cnt_clr(cnt_clr), .fwd_sel(fwd_sel), .stall_id(stall_id),
    .lu_stall(lu_stall), .sb_stall(sb_stall), .pending(pending),
    .stall_cnt(stall_cnt)
  );

  fwd_hazard_unit #(.NUM_SRC(2), .NUM_FWD(2), .AW(5), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .rs_ex(rs_ex), .rd_fwd(rd_fwd),
    .regwrite_fwd(regwrite_fwd), .rs_id(rs_id), .rs_used_id(rs_used_id),
    .memread_ex(memread_ex), .rd_ex(rd_ex), .long_issue(long_issue),
    .long_rd(long_rd), .long_done(long_done), .long_done_rd(long_done_rd),
    .cnt_clr(cnt_clr), .fwd_sel(fwd_sel2), .stall_id(stall_id2),
    .lu_stall(lu_stall2), .sb_stall(sb_stall2), .pending(pending2),
    .stall_cnt(stall_cnt2)
  );

  task automatic drive_idle();
    rst = 1'b0; rs_ex = '0; rd_fwd = '0; regwrite_fwd = '0; rs_id = '0;
    rs_used_id = '0; memread_ex = 1'b0; rd_ex = '0; long_issue = 1'b0;
    long_rd = '0; long_done = 1'b0; long_done_rd = '0; cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); drive_idle(); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    #1;
    e = exp_q.pop_front(); checks++;
    if (pending !== e) begin errors++; $display("FAIL reset_pending got %h want %h", pending, e); end
    e = exp_q.pop_front(); checks++;
    if (stall_cnt !== e[15:0]) begin errors++; $display("FAIL reset_cnt got %0d want %0d", stall_cnt, e[15:0]); end
    e = exp_q.pop_front(); checks++;
    if (stall_cnt2 !== e[1:0]) begin errors++; $display("FAIL reset_cnt2 got %0d want %0d", stall_cnt2, e[1:0]); end
    e = exp_q.pop_front(); checks++;
    if ({lu_stall, sb_stall, stall_id} !== e[2:0]) begin errors++; $display("FAIL reset_stall got %b want %b", {lu_stall, sb_stall, stall_id}, e[2:0]); end
  endtask

  task automatic test_forward();
    logic [9:0] t_rs[7];
    logic [9:0] t_rd[7];
    logic [1:0] t_rw[7];
    logic [3:0] t_ex[7];
    t_rs[0] = {5'd0, 5'd5}; t_rd[0] = {5'd5, 5'd5}; t_rw[0] = 2'b11; t_ex[0] = 4'b0001;
    t_rs[1] = {5'd0, 5'd5}; t_rd[1] = {5'd5, 5'd5}; t_rw[1] = 2'b10; t_ex[1] = 4'b0010;
    t_rs[2] = {5'd0, 5'd5}; t_rd[2] = {5'd0, 5'd0}; t_rw[2] = 2'b11; t_ex[2] = 4'b0000;
    t_rs[3] = {5'd0, 5'd0}; t_rd[3] = {5'd0, 5'd0}; t_rw[3] = 2'b11; t_ex[3] = 4'b0000;
    t_rs[4] = {5'd6, 5'd5}; t_rd[4] = {5'd6, 5'd5}; t_rw[4] = 2'b11; t_ex[4] = 4'b1001;
    t_rs[5] = {5'd5, 5'd5}; t_rd[5] = {5'd5, 5'd9}; t_rw[5] = 2'b11; t_ex[5] = 4'b1010;
    t_rs[6] = {5'd5, 5'd5}; t_rd[6] = {5'd5, 5'd5}; t_rw[6] = 2'b00; t_ex[6] = 4'b0000;
    for (int n = 0; n < 7; n++) begin
      @(negedge clk);
      rs_ex = t_rs[n]; rd_fwd = t_rd[n]; regwrite_fwd = t_rw[n];
      exp_q.push_back({28'd0, t_ex[n]});
      #1;
      e = exp_q.pop_front(); checks++;
      if (fwd_sel !== e[3:0]) begin errors++; $display("FAIL fwd_case%0d got %b want %b", n, fwd_sel, e[3:0]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] rs_v[2];
    logic [4:0] rd_v[2];
    logic [1:0] rw;
    logic [1:0] sel[2];
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        rs_v[i] = 5'($urandom_range(0, 3));
        rd_v[i] = 5'($urandom_range(0, 3));
      end
      rw = 2'($urandom_range(0, 3));
      rs_ex = {rs_v[1], rs_v[0]}; rd_fwd = {rd_v[1], rd_v[0]}; regwrite_fwd = rw;
      for (int i = 0; i < 2; i++) begin
        if (rw[0] && rd_v[0] != 5'd0 && rd_v[0] == rs_v[i]) sel[i] = 2'd1;
        else if (rw[1] && rd_v[1] != 5'd0 && rd_v[1] == rs_v[i]) sel[i] = 2'd2;
        else sel[i] = 2'd0;
      end
      exp_q.push_back({28'd0, sel[1], sel[0]});
      #1;
      e = exp_q.pop_front(); checks++;
      if (fwd_sel !== e[3:0]) begin errors++; $display("FAIL fwd_rand%0d got %b want %b", n, fwd_sel, e[3:0]); end
    end
    @(negedge clk); drive_idle();
  endtask

  task automatic test_load_use();
    logic        t_mr[5];
    logic [4:0]  t_rd[5];
    logic [9:0]  t_id[5];
    logic [1:0]  t_us[5];
    logic [2:0]  t_ex[5];
    t_mr[0] = 1'b1; t_rd[0] = 5'd7; t_id[0] = {5'd7, 5'd0}; t_us[0] = 2'b10; t_ex[0] = 3'b101;
    t_mr[1] = 1'b0; t_rd[1] = 5'd7; t_id[1] = {5'd7, 5'd0}; t_us[1] = 2'b10; t_ex[1] = 3'b000;
    t_mr[2] = 1'b1; t_rd[2] = 5'd7; t_id[2] = {5'd7, 5'd0}; t_us[2] = 2'b00; t_ex[2] = 3'b000;
    t_mr[3] = 1'b1; t_rd[3] = 5'd7; t_id[3] = {5'd0, 5'd7}; t_us[3] = 2'b11; t_ex[3] = 3'b101;
    t_mr[4] = 1'b1; t_rd[4] = 5'd0; t_id[4] = {5'd0, 5'd0}; t_us[4] = 2'b11; t_ex[4] = 3'b000;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      memread_ex = t_mr[n]; rd_ex = t_rd[n]; rs_id = t_id[n]; rs_used_id = t_us[n];
      exp_q.push_back({29'd0, t_ex[n]});
      #1;
      e = exp_q.pop_front(); checks++;
      if ({lu_stall, sb_stall, stall_id} !== e[2:0]) begin errors++; $display("FAIL lu_case%0d got %b want %b", n, {lu_stall, sb_stall, stall_id}, e[2:0]); end
    end
    @(negedge clk); drive_idle();
  endtask

  task automatic test_raw();
    @(negedge clk); drive_idle(); long_issue = 1'b1; long_rd = 5'd9;
    exp_q.push_back(32'd0); #1;
    e = exp_q.pop_front(); checks++;
    if ({lu_stall, sb_stall, stall_id} !== e[2:0]) begin errors++; $display("FAIL raw_issue got %b want %b", {lu_stall, sb_stall, stall_id}, e[2:0]); end
    for (int n = 0; n < 4; n++) begin
      @(negedge clk); drive_idle();
      rs_id = {5'd9, 5'd0}; rs_used_id = 2'b10;
      if (n == 3) begin long_done = 1'b1; long_done_rd = 5'd9; end
      exp_q.push_back(32'd1 << 9); exp_q.push_back(32'd3); #1;
      e = exp_q.pop_front(); checks++;
      if (pending !== e) begin errors++; $display("FAIL raw_pend%0d got %h want %h", n, pending, e); end
      e = exp_q.pop_front(); checks++;
      if ({lu_stall, sb_stall, stall_id} !== e[2:0]) begin errors++; $display("FAIL raw_stall%0d got %b want %b", n, {lu_stall, sb_stall, stall_id}, e[2:0]); end
    end
    @(negedge clk); drive_idle(); rs_id = {5'd9, 5'd0}; rs_used_id = 2'b10;
    exp_q.push_back(32'd0); exp_q.push_back(32'd0); #1;
    e = exp_q.pop_front(); checks++;
    if (pending !== e) begin errors++; $display("FAIL raw_release_pend got %h want %h", pending, e); end
    e = exp_q.pop_front(); checks++;
    if ({lu_stall, sb_stall, stall_id} !== e[2:0]) begin errors++; $display("FAIL raw_release got %b want %b", {lu_stall, sb_stall, stall_id}, e[2:0]); end
  endtask

  task automatic test_waw();
    // Per cycle: inputs, expected pending before the edge, expected stall bits.
    logic        t_is[10];
    logic [4:0]  t_lr[10];
    logic        t_dn[10];
    logic [4:0]  t_dr[10];
    logic [1:0]  t_us[10];
    logic [31:0] t_pd[10];
    logic [2:0]  t_st[10];
    t_is[0]=1'b1; t_lr[0]=5'd3;  t_dn[0]=1'b0; t_dr[0]=5'd0;  t_us[0]=2'b00; t_pd[0]=32'd0;                      t_st[0]=3'b000;
    t_is[1]=1'b1; t_lr[1]=5'd3;  t_dn[1]=1'b0; t_dr[1]=5'd0;  t_us[1]=2'b00; t_pd[1]=32'h0000_0008;             t_st[1]=3'b011;
    t_is[2]=1'b1; t_lr[2]=5'd8;  t_dn[2]=1'b0; t_dr[2]=5'd0;  t_us[2]=2'b01; t_pd[2]=32'h0000_0008;             t_st[2]=3'b011;
    t_is[3]=1'b0; t_lr[3]=5'd0;  t_dn[3]=1'b0; t_dr[3]=5'd0;  t_us[3]=2'b00; t_pd[3]=32'h0000_0008;             t_st[3]=3'b000;
    t_is[4]=1'b1; t_lr[4]=5'd3;  t_dn[4]=1'b1; t_dr[4]=5'd3;  t_us[4]=2'b00; t_pd[4]=32'h0000_0008;             t_st[4]=3'b011;
    t_is[5]=1'b1; t_lr[5]=5'd3;  t_dn[5]=1'b0; t_dr[5]=5'd0;  t_us[5]=2'b00; t_pd[5]=32'd0;                      t_st[5]=3'b000;
    t_is[6]=1'b1; t_lr[6]=5'd12; t_dn[6]=1'b1; t_dr[6]=5'd12; t_us[6]=2'b00; t_pd[6]=32'h0000_0008;             t_st[6]=3'b000;
    t_is[7]=1'b0; t_lr[7]=5'd0;  t_dn[7]=1'b1; t_dr[7]=5'd3;  t_us[7]=2'b00; t_pd[7]=32'h0000_1008;             t_st[7]=3'b000;
    t_is[8]=1'b0; t_lr[8]=5'd0;  t_dn[8]=1'b1; t_dr[8]=5'd12; t_us[8]=2'b00; t_pd[8]=32'h0000_1000;             t_st[8]=3'b000;
    t_is[9]=1'b0; t_lr[9]=5'd0;  t_dn[9]=1'b1; t_dr[9]=5'd20; t_us[9]=2'b00; t_pd[9]=32'd0;                      t_st[9]=3'b000;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk); drive_idle();
      long_issue = t_is[n]; long_rd = t_lr[n]; long_done = t_dn[n]; long_done_rd = t_dr[n];
      rs_id = {5'd0, 5'd3}; rs_used_id = t_us[n];
      exp_q.push_back(t_pd[n]); exp_q.push_back({29'd0, t_st[n]}); #1;
      e = exp_q.pop_front(); checks++;
      if (pending !== e) begin errors++; $display("FAIL waw_pend%0d got %h want %h", n, pending, e); end
      e = exp_q.pop_front(); checks++;
      if ({lu_stall, sb_stall, stall_id} !== e[2:0]) begin errors++; $display("FAIL waw_stall%0d got %b want %b", n, {lu_stall, sb_stall, stall_id}, e[2:0]); end
    end
    @(negedge clk); drive_idle();
    exp_q.push_back(32'd0); #1;
    e = exp_q.pop_front(); checks++;
    if (pending !== e) begin errors++; $display("FAIL waw_spurious_done got %h want %h", pending, e); end
  endtask

  task automatic test_counter();
    @(negedge clk); drive_idle(); cnt_clr = 1'b1;
    for (int n = 0; n <= 6; n++) begin
      @(negedge clk);
      exp_q.push_back(32'(n)); exp_q.push_back(32'((n > 3) ? 3 : n)); #1;
      e = exp_q.pop_front(); checks++;
      if (stall_cnt !== e[15:0]) begin errors++; $display("FAIL cnt_after%0d got %0d want %0d", n, stall_cnt, e[15:0]); end
      e = exp_q.pop_front(); checks++;
      if (stall_cnt2 !== e[1:0]) begin errors++; $display("FAIL cnt2_after%0d got %0d want %0d", n, stall_cnt2, e[1:0]); end
      drive_idle();
      if (n < 6) begin memread_ex = 1'b1; rd_ex = 5'd7; rs_id = {5'd0, 5'd7}; rs_used_id = 2'b01; end
    end
    @(negedge clk);
    memread_ex = 1'b1; rd_ex = 5'd7; rs_id = {5'd0, 5'd7}; rs_used_id = 2'b01; cnt_clr = 1'b1;
    exp_q.push_back(32'd1); #1;
    e = exp_q.pop_front(); checks++;
    if (stall_id !== e[0]) begin errors++; $display("FAIL cnt_clr_stall got %b want %b", stall_id, e[0]); end
    @(negedge clk); drive_idle();
    exp_q.push_back(32'd0); exp_q.push_back(32'd0); #1;
    e = exp_q.pop_front(); checks++;
    if (stall_cnt !== e[15:0]) begin errors++; $display("FAIL cnt_clr_prio got %0d want %0d", stall_cnt, e[15:0]); end
    e = exp_q.pop_front(); checks++;
    if (stall_cnt2 !== e[1:0]) begin errors++; $display("FAIL cnt2_clr_prio got %0d want %0d", stall_cnt2, e[1:0]); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); drive_idle(); long_issue = 1'b1; long_rd = 5'd4;
    @(negedge clk); drive_idle(); long_issue = 1'b1; long_rd = 5'd9;
    @(negedge clk); drive_idle(); memread_ex = 1'b1; rd_ex = 5'd7; rs_id = {5'd7, 5'd0}; rs_used_id = 2'b10;
    @(negedge clk); drive_idle();
    exp_q.push_back((32'd1 << 4) | (32'd1 << 9)); exp_q.push_back(32'd1); #1;
    e = exp_q.pop_front(); checks++;
    if (pending !== e) begin errors++; $display("FAIL rstmid_pre_pend got %h want %h", pending, e); end
    e = exp_q.pop_front(); checks++;
    if (stall_cnt !== e[15:0]) begin errors++; $display("FAIL rstmid_pre_cnt got %0d want %0d", stall_cnt, e[15:0]); end
    rst = 1'b1;
    @(negedge clk); drive_idle(); long_done = 1'b1; long_done_rd = 5'd4;
    exp_q.push_back(32'd0); exp_q.push_back(32'd0); #1;
    e = exp_q.pop_front(); checks++;
    if (pending !== e) begin errors++; $display("FAIL rstmid_pend got %h want %h", pending, e); end
    e = exp_q.pop_front(); checks++;
    if (stall_cnt !== e[15:0]) begin errors++; $display("FAIL rstmid_cnt got %0d want %0d", stall_cnt, e[15:0]); end
    @(negedge clk); drive_idle();
    exp_q.push_back(32'd0); #1;
    e = exp_q.pop_front(); checks++;
    if (pending !== e) begin errors++; $display("FAIL rstmid_stale_done got %h want %h", pending, e); end
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_forward();
    test_back_to_back();
    test_load_use();
    test_raw();
    test_waw();
    test_counter();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog expired");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
